addr_bus_unit: RTL and testbench
================================

// Module: addr_bus_unit
// PURPOSE
//   Address-bus generator for the 65C02 microcoded core: merged low-byte (ABL) and
//   high-byte (ABH) address paths plus the program counter (PCL/PCH) and the
//   operand-latch register AHL.
//   Drives the combinational 16-bit address {ADH,ADL} every cycle from microcode ops.
//   Sits between the control sequencer (ops) and the memory bus; the ALU is separate.
// PARAMETERS
//   none (fixed 8-bit halves, 16-bit address)
// PORTS
//   clk      in   1  CPU clock, all state updates on rising edge
//   RST      in   1  asynchronous, active-low reset
//   abl_op   in   3  ABL operation select (table below)
//   abl_ci   in   1  ABL adder carry-in
//   abh_op   in   3  ABH operation select (table below)
//   abh_ff   in   1  force ADH=8'hFF (vector page), overrides abh_op
//   ld_ahl   in   1  AHL <= DB
//   ld_pc    in   1  PC <= current address {ADH,ADL} (before increment)
//   inc_pc   in   1  increment PC by 1
//   DB       in   8  data bus input
//   REG      in   8  register-file read value (X/Y/A/S/constants)
//   ADL      out  8  address low (combinational)
//   ADH      out  8  address high (combinational)
//   abl_co   out  1  carry out of ABL adder (combinational)
//   PCL      out  8  program counter low (registered)
//   PCH      out  8  program counter high (registered)
// BEHAVIOUR
//   Reset (RST=0, async): ABL, ABH, AHL, PCL, PCH = 8'h00. Outputs follow combinationally.
//   ABL (8-bit add, {abl_co,ADL} = base + index + abl_ci):
//     000 PCL+0+ci   001 ABL+0+ci   010 REG+0+ci   011 DB+0+ci
//     100 AHL+REG+ci 101 DB+REG+ci  110 AHL+0+ci   111 8'h00+0+ci
//   ABH carry-in: abh_ci = abh_op[2] ? abl_co : abh_op[1].
//   ABH (ADH = base + abh_ci, carry out of ABH discarded, wraps FF->00):
//     000 PCH        001 ABH (hold) 010 8'h00 (+1 -> stack page 01)
//     011 ABH (+1, page step)       100 PCH+abl_co  101 ABH+abl_co
//     110 DB+abl_co                  111 8'h00, carry ignored (zero page, no page cross)
//   abh_ff=1: ADH=8'hFF regardless of abh_op.
//   Every clock: ABL<=ADL, ABH<=ADH (registered copies used by ops 001/011/101).
//   AHL: if ld_ahl, AHL<=DB; else hold.
//   PC: {pcl_next,pcl_co} = (ld_pc ? ADL : PCL) + inc_pc;
//       PCH next = (ld_pc ? ADH : PCH) + pcl_co; 16-bit wrap FFFF->0000.
//   ld_pc and inc_pc together: PC <= {ADH,ADL}+1 in one cycle.
//   All address outputs valid same cycle as ops (0 latency); PC/ABx/AHL 1-cycle latency.
//   No X/undefined: every op code defined; unused combinations are not allowed.
// TESTING
//   Reset: RST=0 mid-run -> PCL=PCH=00, ADL/ADH with op 000/000 = 00 immediately.
//   Sequential fetch: PC=12FF, abl_op=000, abh_op=000, inc_pc=1 -> AD=12FF, next PC=1300.
//   Abs,X page cross: AHL=F0, DB=20, REG=20, abl_op=100, abh_op=110 -> ADL=10, abl_co=1, ADH=21.
//   Stack: REG=FD, abl_op=010, abh_op=010 -> AD=01FD; zero page abl_op=101 DB=FF REG=02, abh_op=111 -> AD=0001.
//   Vector: abh_ff=1, REG=FC, abl_op=010 -> AD=FFFC; ld_pc=1, inc_pc=1 -> next PC=FFFD.
//   Hold/increment: ABL=FF,ABH=12, abl_op=001 ci=1, abh_op=101 -> AD=1300; abh_op=011 -> ADH=13.

Source files
------------

// File: rtl/addr_bus_unit.sv
// Address-bus generator for the 65C02 microcoded core: ABL/ABH address paths,
// program counter and operand latch. The address is combinational from the microcode ops.
module addr_bus_unit (
    input  logic       clk,
    input  logic       RST,
    input  logic [2:0] abl_op,
    input  logic       abl_ci,
    input  logic [2:0] abh_op,
    input  logic       abh_ff,
    input  logic       ld_ahl,
    input  logic       ld_pc,
    input  logic       inc_pc,
    input  logic [7:0] DB,
    input  logic [7:0] REG,
    output logic [7:0] ADL,
    output logic [7:0] ADH,
    output logic       abl_co,
    output logic [7:0] PCL,
    output logic [7:0] PCH
);

    logic [7:0] abl_q, abh_q, ahl_q, pcl_q, pch_q;
    logic [7:0] abl_base, abl_index;
    logic [8:0] abl_sum;
    logic [7:0] abh_base;
    logic       abh_ci;
    logic [7:0] pcl_src, pch_src, pcl_d, pch_d;
    logic       pcl_co;

    always_comb begin
        abl_base  = 8'h00;
        abl_index = 8'h00;
        unique case (abl_op)
            3'b000: abl_base = pcl_q;
            3'b001: abl_base = abl_q;
            3'b010: abl_base = REG;
            3'b011: abl_base = DB;
            3'b100: begin
                abl_base  = ahl_q;
                abl_index = REG;
            end
            3'b101: begin
                abl_base  = DB;
                abl_index = REG;
            end
            3'b110: abl_base = ahl_q;
            3'b111: abl_base = 8'h00;
        endcase
        abl_sum = {1'b0, abl_base} + {1'b0, abl_index} + {8'h00, abl_ci};
    end

    assign ADL    = abl_sum[7:0];
    assign abl_co = abl_sum[8];

    // Ops 1xx add the ABL carry; 01x add a constant 1 (stack page / page step).
    always_comb begin
        abh_ci   = abh_op[2] ? abl_co : abh_op[1];
        abh_base = 8'h00;
        unique case (abh_op)
            3'b000: abh_base = pch_q;
            3'b001: abh_base = abh_q;
            3'b010: abh_base = 8'h00;
            3'b011: abh_base = abh_q;
            3'b100: abh_base = pch_q;
            3'b101: abh_base = abh_q;
            3'b110: abh_base = DB;
            3'b111: begin
                abh_base = 8'h00;
                abh_ci   = 1'b0;
            end
        endcase
        ADH = abh_ff ? 8'hFF : abh_base + {7'h00, abh_ci};
    end

    always_comb begin
        pcl_src          = ld_pc ? ADL : pcl_q;
        pch_src          = ld_pc ? ADH : pch_q;
        {pcl_co, pcl_d}  = {1'b0, pcl_src} + {8'h00, inc_pc};
        pch_d            = pch_src + {7'h00, pcl_co};
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            abl_q <= 8'h00;
            abh_q <= 8'h00;
            ahl_q <= 8'h00;
            pcl_q <= 8'h00;
            pch_q <= 8'h00;
        end else begin
            abl_q <= ADL;
            abh_q <= ADH;
            if (ld_ahl) ahl_q <= DB;
            pcl_q <= pcl_d;
            pch_q <= pch_d;
        end
    end

    assign PCL = pcl_q;
    assign PCH = pch_q;

endmodule

// File: tb/tb_addr_bus_unit.sv
// Scoreboard bench for addr_bus_unit: random microcode ops checked against an
// arithmetic reference model, plus directed address-mode scenarios.
module tb_addr_bus_unit;

    logic       clk = 1'b0;
    logic       RST;
    logic [2:0] abl_op, abh_op;
    logic       abl_ci, abh_ff, ld_ahl, ld_pc, inc_pc;
    logic [7:0] DB, REG;
    logic [7:0] ADL, ADH, PCL, PCH;
    logic       abl_co;

    addr_bus_unit dut (
        .clk    (clk),
        .RST    (RST),
        .abl_op (abl_op),
        .abl_ci (abl_ci),
        .abh_op (abh_op),
        .abh_ff (abh_ff),
        .ld_ahl (ld_ahl),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .DB     (DB),
        .REG    (REG),
        .ADL    (ADL),
        .ADH    (ADH),
        .abl_co (abl_co),
        .PCL    (PCL),
        .PCH    (PCH)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ad;
        logic        co;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (plain integers)
    int m_abl = 0, m_abh = 0, m_ahl = 0, m_pc = 0;
    int n_abl = 0, n_abh = 0, n_ahl = 0, n_pc = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] ao, input logic aci, input logic [2:0] ho,
                         input logic ff, input logic lahl, input logic lpc, input logic ipc,
                         input logic [7:0] db, input logic [7:0] rg);
        int   base, idx, sum, adl, co, adh, src;
        exp_t e;
        abl_op = ao; abl_ci = aci; abh_op = ho; abh_ff = ff;
        ld_ahl = lahl; ld_pc = lpc; inc_pc = ipc; DB = db; REG = rg;
        idx = 0;
        case (ao)
            3'd0: base = m_pc % 256;
            3'd1: base = m_abl;
            3'd2: base = int'(rg);
            3'd3: base = int'(db);
            3'd4: begin base = m_ahl; idx = int'(rg); end
            3'd5: begin base = int'(db); idx = int'(rg); end
            3'd6: base = m_ahl;
            default: base = 0;
        endcase
        sum = base + idx + int'(aci);
        adl = sum % 256;
        co  = sum / 256;
        case (ho)
            3'd0: adh = m_pc / 256;
            3'd1: adh = m_abh;
            3'd2: adh = 1;
            3'd3: adh = m_abh + 1;
            3'd4: adh = m_pc / 256 + co;
            3'd5: adh = m_abh + co;
            3'd6: adh = int'(db) + co;
            default: adh = 0;
        endcase
        adh = ff ? 255 : adh % 256;
        src   = lpc ? adh * 256 + adl : m_pc;
        n_pc  = (src + int'(ipc)) % 65536;
        n_abl = adl;
        n_abh = adh;
        n_ahl = lahl ? int'(db) : m_ahl;
        e.ad = 16'(adh * 256 + adl);
        e.co = co[0];
        e.pc = 16'(m_pc);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        if (RST) begin
            m_abl = n_abl; m_abh = n_abh; m_ahl = n_ahl; m_pc = n_pc;
        end else begin
            m_abl = 0; m_abh = 0; m_ahl = 0; m_pc = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        m_abl = 0; m_abh = 0; m_ahl = 0; m_pc = 0;
        drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("reset_pc", {PCH, PCL}, 16'h0000);
        chk("reset_ad", {ADH, ADL}, 16'h0000);
        @(negedge clk);
        @(posedge clk);
        #1;
        RST = 1'b1;
    endtask

    // Monitor: compares DUT outputs against the oldest scoreboard entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_ad", {ADH, ADL}, e.ad);
                chk("sb_abl_co", {15'h0, abl_co}, {15'h0, e.co});
                chk("sb_pc", {PCH, PCL}, e.pc);
            end
        end
    end

    initial begin
        do_reset();

        // Sequential fetch across a page boundary
        drive(3'd2, 1'b0, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 8'hFF);
        tick();
        drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        #1 chk("fetch_ad", {ADH, ADL}, 16'h12FF);
        tick();
        chk("fetch_pc", {PCH, PCL}, 16'h1300);

        // Absolute,X with page cross
        drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h00);
        tick();
        drive(3'd4, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h20);
        #1 chk("absx_ad", {ADH, ADL}, 16'h2110);
        chk("absx_co", {15'h0, abl_co}, 16'h0001);
        tick();

        // Stack page, then zero page wrap without page cross
        drive(3'd2, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFD);
        #1 chk("stack_ad", {ADH, ADL}, 16'h01FD);
        tick();
        drive(3'd5, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h02);
        #1 chk("zp_ad", {ADH, ADL}, 16'h0001);
        tick();

        // Vector fetch with PC load and increment
        drive(3'd2, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFC);
        #1 chk("vec_ad", {ADH, ADL}, 16'hFFFC);
        tick();
        chk("vec_pc", {PCH, PCL}, 16'hFFFD);

        // Hold/increment from ABL=FF, ABH=12
        drive(3'd2, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 8'hFF);
        tick();
        drive(3'd1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1 chk("hold_inc_ad", {ADH, ADL}, 16'h1300);
        tick();
        drive(3'd2, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 8'hFF);
        tick();
        drive(3'd1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1 chk("page_step_adh", {8'h00, ADH}, 16'h0013);
        tick();

        // Randomized ops, with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            drive(3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                  1'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
